// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Definitions shared by tstate_sequencer and
//                controller_sequencer: instruction-length and step-mode
//                encodings, the last T-state of each instruction length,
//                and the width of the one-hot T-state vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Width of the one-hot T-state vector (T0..T14).
    localparam int RC_WIDTH = 15;

    // Instruction length reported by the controller.
    typedef enum logic [1:0] {
        MODE_1B   = 2'b00,
        MODE_2B   = 2'b01,
        MODE_3B   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Debug stepping modes.
    typedef enum logic [1:0] {
        STEP_RUN    = 2'b00,
        STEP_TSTATE = 2'b01,
        STEP_INSTR  = 2'b10,
        STEP_RSVD   = 2'b11
    } step_mode_e;

    // Index of the final micro-step for each instruction length.
    localparam logic [3:0] LAST_T_1B = 4'd5;
    localparam logic [3:0] LAST_T_2B = 4'd9;
    localparam logic [3:0] LAST_T_3B = 4'd13;

    // Final T-state for a given instruction length. The reserved encoding
    // behaves like a 1-byte instruction so the machine keeps cycling.
    function automatic logic [3:0] last_t_for_mode(input logic [1:0] mode_in);
        logic [3:0] last_t;
        case (mode_in)
            MODE_1B: last_t = LAST_T_1B;
            MODE_2B: last_t = LAST_T_2B;
            MODE_3B: last_t = LAST_T_3B;
            default: last_t = LAST_T_1B;
        endcase
        return last_t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : step_edge_detect
//  Description : Rising-edge detector for the debug-panel step request.
//                The history register resets to 1 so that a request held
//                high through reset is not seen as a fresh edge.
//  Ports       : clk       - system clock
//                rst       - asynchronous active-high reset
//                step_req  - step request level
//                step_edge - high for the cycle in which step_req rises
//  Revision    : 1.0 - initial release
// ============================================================================
module step_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic step_req,
    output logic step_edge
);

    logic r_step_req_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_req_d <= 1'b1;
        end else begin
            r_step_req_d <= step_req;
        end
    end

    assign step_edge = step_req & ~r_step_req_d;

endmodule
`default_nettype wire

// File: rtl/tstate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tstate_sequencer
//  Description : One-hot T-state ring counter for controller_sequencer.
//                Wraps at the last micro-step of the current instruction
//                length, freezes on HLT, and supports run, T-state-step and
//                instruction-step debug modes.
//  Ports       : clk, rst            - clock, async active-high reset
//                enable_ring_counter - 0 = HLT
//                mode                - instruction length (1/2/3 byte)
//                clear_cpu           - synchronous restart to T0
//                step_mode, step_req - debug stepping control
//                ring_counter        - one-hot T-state
//                t_index             - binary index of the T-state
//                instr_start         - ring_counter is T0
//                step_ack            - step-granted advance this cycle
//                paused, halted      - status flags
//                illegal_mode        - reserved mode seen at a wrap
//                instr_count         - instructions retired
//  Revision    : 1.0 - initial release
// ============================================================================
module tstate_sequencer #(
    parameter int RC_WIDTH  = cpu_pkg::RC_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_ring_counter,
    input  logic [1:0]           mode,
    input  logic                 clear_cpu,
    input  logic [1:0]           step_mode,
    input  logic                 step_req,
    output logic [RC_WIDTH-1:0]  ring_counter,
    output logic [3:0]           t_index,
    output logic                 instr_start,
    output logic                 step_ack,
    output logic                 paused,
    output logic                 halted,
    output logic                 illegal_mode,
    output logic [CNT_WIDTH-1:0] instr_count
);

    import cpu_pkg::*;

    localparam logic [RC_WIDTH-1:0] c_t0 = RC_WIDTH'(1);

    logic [RC_WIDTH-1:0]  r_ring;
    logic                 r_halted;
    logic                 r_illegal;
    logic [CNT_WIDTH-1:0] r_count;

    logic                 w_step_edge;
    logic [1:0]           w_step_mode;
    logic                 w_at_t0;
    logic                 w_valid;
    logic [3:0]           w_t_index;
    logic                 w_is_last;
    logic                 w_grant;
    logic                 w_step_grant;
    logic                 w_paused;
    logic                 w_advance;
    logic [RC_WIDTH-1:0]  w_ring_next;

    step_edge_detect u_step_edge_detect (
        .clk       (clk),
        .rst       (rst),
        .step_req  (step_req),
        .step_edge (w_step_edge)
    );

    // Index of the lowest asserted bit; only meaningful when the vector is
    // one-hot, which is the only case in which it is used for wrapping.
    always_comb begin
        w_t_index = 4'd0;
        for (int i = RC_WIDTH - 1; i >= 0; i--) begin
            if (r_ring[i]) begin
                w_t_index = 4'(i);
            end
        end
    end

    always_comb begin
        w_step_mode = (step_mode == STEP_RSVD) ? STEP_RUN : step_mode;
        w_at_t0     = (r_ring == c_t0);
        // The top T-state is never legitimately reached, so it is treated
        // like a corrupted vector and forces a restart at T0.
        w_valid     = (r_ring != '0) &&
                      ((r_ring & (r_ring - RC_WIDTH'(1))) == '0) &&
                      !r_ring[RC_WIDTH-1];
        w_is_last   = w_valid && (w_t_index == last_t_for_mode(mode));

        w_grant      = 1'b1;
        w_step_grant = 1'b0;
        w_paused     = 1'b0;
        case (w_step_mode)
            STEP_TSTATE: begin
                // Always waiting; each accepted edge is exactly one advance.
                w_grant      = w_step_edge;
                w_step_grant = w_step_edge;
                w_paused     = 1'b1;
            end
            STEP_INSTR: begin
                // Away from T0 the instruction free-runs to completion, so a
                // mid-instruction edge has no extra effect. At T0 it waits.
                w_grant      = !w_at_t0 || w_step_edge;
                w_step_grant = w_at_t0 && w_step_edge;
                w_paused     = w_at_t0;
            end
            default: begin
                w_grant      = 1'b1;
                w_step_grant = 1'b0;
                w_paused     = 1'b0;
            end
        endcase

        w_advance = enable_ring_counter && !r_halted && !clear_cpu && w_grant;

        if (!w_valid || w_is_last) begin
            w_ring_next = c_t0;
        end else begin
            w_ring_next = r_ring << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ring    <= c_t0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else if (clear_cpu) begin
            r_ring    <= c_t0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else if (!enable_ring_counter && !r_halted) begin
            r_halted  <= 1'b1;
        end else if (w_advance) begin
            r_ring <= w_ring_next;
            if (w_is_last) begin
                r_count <= r_count + CNT_WIDTH'(1);
                if (mode == MODE_RSVD) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    assign ring_counter = r_ring;
    assign t_index      = w_t_index;
    assign instr_start  = w_at_t0;
    assign step_ack     = w_advance && w_step_grant;
    assign paused       = w_paused;
    assign halted       = r_halted;
    assign illegal_mode = r_illegal;
    assign instr_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_tstate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tstate_sequencer
//  Description : Directed self-checking bench for tstate_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tstate_sequencer;

    logic        clk;
    logic        rst;
    logic        enable_ring_counter;
    logic [1:0]  mode;
    logic        clear_cpu;
    logic [1:0]  step_mode;
    logic        step_req;
    logic [14:0] ring_counter;
    logic [3:0]  t_index;
    logic        instr_start;
    logic        step_ack;
    logic        paused;
    logic        halted;
    logic        illegal_mode;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    tstate_sequencer #(
        .RC_WIDTH  (15),
        .CNT_WIDTH (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable_ring_counter (enable_ring_counter),
        .mode                (mode),
        .clear_cpu           (clear_cpu),
        .step_mode           (step_mode),
        .step_req            (step_req),
        .ring_counter        (ring_counter),
        .t_index             (t_index),
        .instr_start         (instr_start),
        .step_ack            (step_ack),
        .paused              (paused),
        .halted              (halted),
        .illegal_mode        (illegal_mode),
        .instr_count         (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [14:0] exp_ring;

        rst                 = 1'b1;
        enable_ring_counter = 1'b1;
        mode                = 2'b00;
        clear_cpu           = 1'b0;
        step_mode           = 2'b00;
        step_req            = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ring", 32'(ring_counter), 32'h0001);
        check("rst_tidx", 32'(t_index), 0);
        check("rst_istart", 32'(instr_start), 1);
        check("rst_ack", 32'(step_ack), 0);
        check("rst_paused", 32'(paused), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal_mode), 0);
        check("rst_count", 32'(instr_count), 0);
        rst = 1'b0;

        // Run, 1-byte: T0..T5 then T0, two instructions
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_ring = 15'd1 << (k % 6);
            check("run1b_ring", 32'(ring_counter), 32'(exp_ring));
            check("run1b_count", 32'(instr_count), 32'(k / 6));
        end
        check("run1b_istart", 32'(instr_start), 1);

        // Run, 3-byte: 14 states
        mode = 2'b10;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            exp_ring = 15'd1 << (k % 14);
            check("run3b_ring", 32'(ring_counter), 32'(exp_ring));
        end
        check("run3b_count", 32'(instr_count), 3);

        // Run, 2-byte: 10 states
        mode = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_ring = 15'd1 << (k % 10);
            check("run2b_ring", 32'(ring_counter), 32'(exp_ring));
        end
        check("run2b_count", 32'(instr_count), 4);

        // HLT at T4
        mode = 2'b00;
        repeat (4) @(negedge clk);
        check("hlt_pre_tidx", 32'(t_index), 4);
        enable_ring_counter = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hlt_ring", 32'(ring_counter), 32'h0010);
            check("hlt_halted", 32'(halted), 1);
        end
        enable_ring_counter = 1'b1;
        @(negedge clk);
        check("hlt_sticky_ring", 32'(ring_counter), 32'h0010);
        check("hlt_sticky", 32'(halted), 1);
        clear_cpu = 1'b1;
        @(negedge clk);
        check("clr_ring", 32'(ring_counter), 32'h0001);
        check("clr_halted", 32'(halted), 0);
        check("clr_count", 32'(instr_count), 0);
        clear_cpu = 1'b0;
        step_mode = 2'b01;

        // T-state step
        @(negedge clk);
        check("ts_idle_ring", 32'(ring_counter), 32'h0001);
        check("ts_idle_paused", 32'(paused), 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            step_req = 1'b1;
            #1;
            check("ts_ack", 32'(step_ack), 1);
            @(negedge clk);
            check("ts_tidx", 32'(t_index), 32'(i));
            check("ts_ack_clear", 32'(step_ack), 0);
            step_req = 1'b0;
        end
        check("ts_ring_t3", 32'(ring_counter), 32'h0008);
        @(negedge clk);
        step_req = 1'b1;
        repeat (5) @(negedge clk);
        check("ts_held_tidx", 32'(t_index), 4);
        step_req = 1'b0;

        // Instruction step, 1-byte
        @(negedge clk);
        clear_cpu = 1'b1;
        step_mode = 2'b10;
        @(negedge clk);
        clear_cpu = 1'b0;
        check("is_clr_ring", 32'(ring_counter), 32'h0001);
        check("is_clr_paused", 32'(paused), 1);
        @(negedge clk);
        check("is_wait_ring", 32'(ring_counter), 32'h0001);
        step_req = 1'b1;
        #1;
        check("is_ack", 32'(step_ack), 1);
        @(negedge clk);
        check("is_t1", 32'(t_index), 1);
        check("is_run_paused", 32'(paused), 0);
        step_req = 1'b0;
        @(negedge clk);
        check("is_t2", 32'(t_index), 2);
        step_req = 1'b1;
        #1;
        check("is_mid_ack", 32'(step_ack), 0);
        @(negedge clk);
        check("is_t3", 32'(t_index), 3);
        step_req = 1'b0;
        @(negedge clk);
        check("is_t4", 32'(t_index), 4);
        @(negedge clk);
        check("is_t5", 32'(t_index), 5);
        @(negedge clk);
        check("is_wrap_ring", 32'(ring_counter), 32'h0001);
        check("is_wrap_count", 32'(instr_count), 1);
        check("is_wrap_paused", 32'(paused), 1);
        @(negedge clk);
        check("is_hold_ring", 32'(ring_counter), 32'h0001);

        // Reserved mode wraps after T5 and sets the sticky flag
        step_mode = 2'b00;
        mode      = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_ring = 15'd1 << (k % 6);
            check("rsvd_ring", 32'(ring_counter), 32'(exp_ring));
            if (k == 5) check("rsvd_pre_illegal", 32'(illegal_mode), 0);
        end
        check("rsvd_illegal", 32'(illegal_mode), 1);
        check("rsvd_count", 32'(instr_count), 2);
        mode = 2'b01;
        repeat (7) @(negedge clk);
        check("rsvd_t7", 32'(t_index), 7);
        check("rsvd_sticky", 32'(illegal_mode), 1);

        // Async reset in the middle of T7
        #2;
        rst = 1'b1;
        #1;
        check("arst_ring", 32'(ring_counter), 32'h0001);
        check("arst_illegal", 32'(illegal_mode), 0);
        check("arst_count", 32'(instr_count), 0);
        check("arst_halted", 32'(halted), 0);
        @(negedge clk);
        check("arst_hold_ring", 32'(ring_counter), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
